// File: rtl/uart_dbg_pkg.sv
// Shared constants and types for the UART debugger link.
// Both the transmit and receive paths import this package.
package uart_dbg_pkg;

  localparam int DATA_BITS       = 8;
  localparam int DEFAULT_CLK_DIV = 434;

  localparam logic IDLE_LEVEL  = 1'b1;
  localparam logic START_LEVEL = 1'b0;
  localparam logic STOP_LEVEL  = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } txState_e;

endpackage

// File: rtl/uart_tx_engine_if.sv
// Byte-source handshake and serial-side status of the UART transmit engine.
// The master is the response logic; the slave is the engine.
interface uart_tx_engine_if;
  import uart_dbg_pkg::*;

  logic                 tx_valid;
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_ready;
  logic                 tx;
  logic                 tx_busy;
  logic                 tx_done;

  modport master (
    output tx_valid, tx_data,
    input  tx_ready, tx, tx_busy, tx_done
  );

  modport slave (
    input  tx_valid, tx_data,
    output tx_ready, tx, tx_busy, tx_done
  );

endinterface

// File: rtl/uart_baud_counter.sv
// Bit-period timer shared by the UART transmit and receive paths.
// bit_end marks the last clk of each CLK_DIV-long bit period.
module uart_baud_counter #(
  parameter int CLK_DIV = 434
) (
  input  logic clk,
  input  logic n_Rst,
  input  logic clear,
  output logic bit_end,
  output logic bit_end_next
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q + 1'b1;
    if (clear || (count_q == LAST)) begin
      count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!n_Rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // bit_end_next lets callers register a pulse that lines up with bit_end
  assign bit_end      = (count_q == LAST);
  assign bit_end_next = (count_d == LAST);

endmodule

// File: rtl/uart_tx_engine.sv
// UART transmit engine: serialises one byte into an 8N1 frame, LSB first.
// Every output comes straight from a register.
module uart_tx_engine
  import uart_dbg_pkg::*;
#(
  parameter int CLK_DIV = DEFAULT_CLK_DIV
) (
  input logic clk,
  input logic n_Rst,
  uart_tx_engine_if.slave tx_if
);

  localparam int BW = $clog2(DATA_BITS);

  txState_e             state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [BW-1:0]        bitCnt_q, bitCnt_d;
  logic                 tx_q, tx_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic bitEnd;
  logic bitEndNext;
  logic baudClear;

  // Holding the counter clear in IDLE gives the start bit a full period
  assign baudClear = (state_q == IDLE);

  uart_baud_counter #(
    .CLK_DIV(CLK_DIV)
  ) u_baud (
    .clk         (clk),
    .n_Rst       (n_Rst),
    .clear       (baudClear),
    .bit_end     (bitEnd),
    .bit_end_next(bitEndNext)
  );

  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    bitCnt_d = bitCnt_q;
    tx_d     = tx_q;
    busy_d   = busy_q;
    case (state_q)
      IDLE: begin
        if (tx_if.tx_valid) begin
          state_d  = START;
          shift_d  = tx_if.tx_data;
          bitCnt_d = '0;
          tx_d     = START_LEVEL;
          busy_d   = 1'b1;
        end
      end
      START: begin
        if (bitEnd) begin
          state_d  = DATA;
          bitCnt_d = '0;
          tx_d     = shift_q[0];
        end
      end
      DATA: begin
        if (bitEnd) begin
          shift_d = shift_q >> 1;
          if (bitCnt_q == BW'(DATA_BITS - 1)) begin
            state_d  = STOP;
            bitCnt_d = '0;
            tx_d     = STOP_LEVEL;
          end else begin
            bitCnt_d = bitCnt_q + 1'b1;
            tx_d     = shift_d[0];
          end
        end
      end
      STOP: begin
        if (bitEnd) begin
          state_d = IDLE;
          tx_d    = IDLE_LEVEL;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = IDLE_LEVEL;
        busy_d  = 1'b0;
      end
    endcase
    // Registered so the pulse sits on the final stop clk, not one after it
    done_d = (state_d == STOP) && bitEndNext;
  end

  always_ff @(posedge clk) begin
    if (!n_Rst) begin
      state_q  <= IDLE;
      shift_q  <= '0;
      bitCnt_q <= '0;
      tx_q     <= IDLE_LEVEL;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      bitCnt_q <= bitCnt_d;
      tx_q     <= tx_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign tx_if.tx       = tx_q;
  assign tx_if.tx_busy  = busy_q;
  assign tx_if.tx_ready = ~busy_q;
  assign tx_if.tx_done  = done_q;

endmodule

// File: tb/tb_uart_tx_engine.sv
// Directed bench for uart_tx_engine: a fast CLK_DIV=4 instance and a
// full-rate CLK_DIV=434 instance, both decoded by a bit-level frame model.
module tb_uart_tx_engine;
  import uart_dbg_pkg::*;

  localparam int DIV_A = 4;
  localparam int DIV_B = 434;

  logic clk = 1'b0;
  logic n_Rst;

  int total = 0;
  int bad   = 0;

  logic [7:0] bListB [3] = '{8'h00, 8'hA5, 8'hFF};

  uart_tx_engine_if ifA ();
  uart_tx_engine_if ifB ();

  uart_tx_engine #(.CLK_DIV(DIV_A)) dutA (.clk(clk), .n_Rst(n_Rst), .tx_if(ifA));
  uart_tx_engine #(.CLK_DIV(DIV_B)) dutB (.clk(clk), .n_Rst(n_Rst), .tx_if(ifB));

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic sampleDut(input int sel, output logic t, output logic dn,
                           output logic rdy, output logic bsy);
    if (sel == 0) begin
      t = ifA.tx; dn = ifA.tx_done; rdy = ifA.tx_ready; bsy = ifA.tx_busy;
    end else begin
      t = ifB.tx; dn = ifB.tx_done; rdy = ifB.tx_ready; bsy = ifB.tx_busy;
    end
  endtask

  // Called on a negedge; presents one byte for exactly one clk
  task automatic applyStimulus(input int sel, input logic [7:0] b);
    if (sel == 0) begin
      ifA.tx_valid = 1'b1; ifA.tx_data = b;
    end else begin
      ifB.tx_valid = 1'b1; ifB.tx_data = b;
    end
    @(negedge clk);
    if (sel == 0) ifA.tx_valid = 1'b0;
    else          ifB.tx_valid = 1'b0;
  endtask

  // Entered on the negedge of the first start-bit clk; walks the whole frame
  task automatic checkFrame(input int sel, input logic [7:0] expByte, input string tag,
                            input int injAt, input logic [7:0] injByte);
    int div;
    int txErr, doneCnt, doneAt, busyErr;
    logic [9:0] expBits;
    logic [7:0] dec;
    logic t, dn, rdy, bsy;
    div     = (sel == 0) ? DIV_A : DIV_B;
    txErr   = 0;
    doneCnt = 0;
    doneAt  = -1;
    busyErr = 0;
    dec     = 8'h00;
    expBits = {1'b1, expByte, 1'b0};
    for (int c = 0; c < 10 * div; c++) begin
      if (sel == 0 && c == injAt) begin
        ifA.tx_valid = 1'b1;
        ifA.tx_data  = injByte;
      end
      sampleDut(sel, t, dn, rdy, bsy);
      if (t !== expBits[c / div]) txErr++;
      if ((c % div) == (div / 2) && (c / div) >= 1 && (c / div) <= 8) dec[c / div - 1] = t;
      if (dn === 1'b1) begin
        doneCnt++;
        doneAt = c;
      end
      if (rdy !== 1'b0 || bsy !== 1'b1) busyErr++;
      @(negedge clk);
    end
    sampleDut(sel, t, dn, rdy, bsy);
    checkOutput({tag, "_bits"}, txErr, 0);
    checkOutput({tag, "_byte"}, {24'h0, dec}, {24'h0, expByte});
    checkOutput({tag, "_doneCnt"}, doneCnt, 1);
    checkOutput({tag, "_doneAt"}, doneAt, 10 * div - 1);
    checkOutput({tag, "_busy"}, busyErr, 0);
    checkOutput({tag, "_readyBack"}, {28'h0, rdy, bsy, dn, t}, 32'h9);
  endtask

  initial begin
    logic t, dn, rdy, bsy;
    int errs;
    int doneSeen;

    n_Rst = 1'b0;
    ifA.tx_valid = 1'b0; ifA.tx_data = 8'h00;
    ifB.tx_valid = 1'b0; ifB.tx_data = 8'h00;

    repeat (3) @(negedge clk);
    sampleDut(0, t, dn, rdy, bsy);
    checkOutput("rst_tx", t, 1);
    checkOutput("rst_ready", rdy, 1);
    checkOutput("rst_busy", bsy, 0);
    checkOutput("rst_done", dn, 0);
    n_Rst = 1'b1;

    errs = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      sampleDut(0, t, dn, rdy, bsy);
      if ({t, rdy, bsy, dn} !== 4'b1100) errs++;
    end
    checkOutput("idle_steady", errs, 0);

    applyStimulus(0, 8'hA5);
    checkFrame(0, 8'hA5, "a5", -1, 8'h00);
    @(negedge clk);

    // Held valid: 0x00 then 0xFF, data switched while the first frame runs
    ifA.tx_valid = 1'b1; ifA.tx_data = 8'h00;
    @(negedge clk);
    ifA.tx_data = 8'hFF;
    checkFrame(0, 8'h00, "b2b0", -1, 8'h00);
    @(negedge clk);
    ifA.tx_valid = 1'b0;
    checkFrame(0, 8'hFF, "b2b1", -1, 8'h00);
    @(negedge clk);

    applyStimulus(0, 8'h3C);
    checkFrame(0, 8'h3C, "chg", 2 * DIV_A, 8'hC3);
    @(negedge clk);
    ifA.tx_valid = 1'b0;
    checkFrame(0, 8'hC3, "chgNext", -1, 8'h00);
    @(negedge clk);

    // Abort 0x55 while bit 3 (clks 16..19 of the frame) is on the line
    applyStimulus(0, 8'h55);
    doneSeen = 0;
    for (int c = 0; c < 17; c++) begin
      sampleDut(0, t, dn, rdy, bsy);
      if (dn === 1'b1) doneSeen++;
      @(negedge clk);
    end
    sampleDut(0, t, dn, rdy, bsy);
    checkOutput("abort_pre", t, 0);
    n_Rst = 1'b0;
    @(negedge clk);
    sampleDut(0, t, dn, rdy, bsy);
    checkOutput("abort_tx", t, 1);
    checkOutput("abort_state", {rdy, bsy, dn}, 3'b100);
    n_Rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      sampleDut(0, t, dn, rdy, bsy);
      if (dn === 1'b1 || t !== 1'b1) doneSeen++;
    end
    checkOutput("abort_quiet", doneSeen, 0);
    applyStimulus(0, 8'h81);
    checkFrame(0, 8'h81, "afterAbort", -1, 8'h00);

    for (int b = 0; b < 256; b++) begin
      @(negedge clk);
      applyStimulus(0, 8'(b));
      checkFrame(0, 8'(b), "loopA", -1, 8'h00);
    end

    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      applyStimulus(1, bListB[i]);
      checkFrame(1, bListB[i], "loopB", -1, 8'h00);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
